auto_contrast_ctrl: RTL

Closed-loop controller that drives the contrast stage's `inc`/`dec` inputs. Sits beside the contrast stage on the same pixel stream. Each frame it measures the luma spread (max − min), compares it with a target window, and issues at most one single-cycle `inc` or `dec` request, using the contrast stage's current level as feedback. Manual key requests pass through with priority.

---
 rtl/tmz_video_pkg.sv | 31 +++
 rtl/luma_minmax.sv | 48 ++++
 rtl/auto_contrast_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tmz_video_pkg.sv
// rtl/tmz_video_pkg.sv - shared types and constants for the auto-contrast controller
package tmz_video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DECIDE,
    ST_PULSE,
    ST_HOLD
  } acc_state_e;

  typedef logic [7:0] pix8_t;

  localparam logic [9:0] LUMA_WR    = 10'd1;
  localparam logic [9:0] LUMA_WG    = 10'd2;
  localparam logic [9:0] LUMA_WB    = 10'd1;
  localparam int         LUMA_SHIFT = 2;

  localparam logic [3:0] LEVEL_MIN = 4'h0;
  localparam logic [3:0] LEVEL_MAX = 4'hF;

  // Weighted sum peaks at 4*255, so 10 bits never overflow.
  function automatic pix8_t luma8(input pix8_t r, input pix8_t g, input pix8_t b);
    logic [9:0] sum;
    logic [9:0] sh;
    sum = {2'b00, r} * LUMA_WR + {2'b00, g} * LUMA_WG + {2'b00, b} * LUMA_WB;
    sh  = sum >> LUMA_SHIFT;
    return sh[7:0];
  endfunction

endpackage

// File: rtl/luma_minmax.sv
// rtl/luma_minmax.sv - per-frame luma min/max tracking and spread latch
module luma_minmax
  import tmz_video_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_frame_start,
  input  logic  i_pix_valid,
  input  pix8_t i_r,
  input  pix8_t i_g,
  input  pix8_t i_b,
  output pix8_t o_spread,
  output logic  o_had_pix
);

  pix8_t w_y;
  pix8_t r_ymin;
  pix8_t r_ymax;
  pix8_t r_spread;
  logic  r_any;
  logic  r_had_pix;

  assign w_y       = luma8(i_r, i_g, i_b);
  assign o_spread  = r_spread;
  assign o_had_pix = r_had_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ymin    <= 8'hFF;
      r_ymax    <= 8'h00;
      r_any     <= 1'b0;
      r_spread  <= 8'h00;
      r_had_pix <= 1'b0;
    end else if (i_frame_start) begin
      r_spread  <= r_any ? (r_ymax - r_ymin) : 8'h00;
      r_had_pix <= r_any;
      // A pixel coinciding with frame_start opens the new frame.
      r_ymin    <= i_pix_valid ? w_y : 8'hFF;
      r_ymax    <= i_pix_valid ? w_y : 8'h00;
      r_any     <= i_pix_valid;
    end else if (i_pix_valid) begin
      if (w_y < r_ymin) r_ymin <= w_y;
      if (w_y > r_ymax) r_ymax <= w_y;
      r_any <= 1'b1;
    end
  end

endmodule

// File: rtl/auto_contrast_ctrl.sv
// rtl/auto_contrast_ctrl.sv - closed-loop contrast inc/dec requester with manual key override
// Optional frame hold-off after each request: AUTO_CONTRAST_HOLDOFF_EN.
module auto_contrast_ctrl
  import tmz_video_pkg::*;
#(
  parameter logic [7:0] LOW_TH         = 8'd96,
  parameter logic [7:0] HIGH_TH        = 8'd224,
  parameter int         HOLDOFF_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic [3:0] level_in,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic       inc,
  output logic       dec,
  output logic [7:0] spread,
  output logic       frame_seen
);

  acc_state_e r_state;
  logic       r_inc;
  logic       r_dec;
  logic       r_started;
  logic       r_seen;
  pix8_t      w_spread;
  logic       w_had_pix;
  logic       w_key;
  logic       w_want_inc;
  logic       w_want_dec;

`ifdef AUTO_CONTRAST_HOLDOFF_EN
  localparam int CNT_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_FRAMES);
  logic [CNT_W-1:0] r_hold_cnt;
`else
  logic w_unused_holdoff;
  assign w_unused_holdoff = (HOLDOFF_FRAMES != 0);
`endif

  luma_minmax u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_start(frame_start),
    .i_pix_valid  (pix_valid),
    .i_r          (r),
    .i_g          (g),
    .i_b          (b),
    .o_spread     (w_spread),
    .o_had_pix    (w_had_pix)
  );

  assign w_key      = key_inc | key_dec;
  assign w_want_inc = w_had_pix && (w_spread < LOW_TH) && (level_in < LEVEL_MAX);
  assign w_want_dec = w_had_pix && (w_spread > HIGH_TH) && (level_in > LEVEL_MIN);

  assign inc        = r_inc;
  assign dec        = r_dec;
  assign spread     = w_spread;
  assign frame_seen = r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_started <= 1'b0;
      r_seen    <= 1'b0;
`ifdef AUTO_CONTRAST_HOLDOFF_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      if (frame_start) begin
        r_started <= 1'b1;
        if (r_started) r_seen <= 1'b1;
      end
      // Manual keys win over anything the FSM would issue this cycle.
      if (w_key) begin
        r_inc <= key_inc;
        r_dec <= ~key_inc;
`ifdef AUTO_CONTRAST_HOLDOFF_EN
        r_hold_cnt <= HOLD_LOAD;
        r_state    <= (HOLD_LOAD != '0) ? ST_HOLD : ST_ACCUM;
`else
        r_state    <= ST_ACCUM;
`endif
      end else begin
        case (r_state)
          ST_IDLE:   if (frame_start) r_state <= ST_ACCUM;
          ST_ACCUM:  if (frame_start) r_state <= ST_DECIDE;
          ST_DECIDE: begin
            if (enable && (w_want_inc || w_want_dec)) begin
              r_state <= ST_PULSE;
              r_inc   <= w_want_inc;
              r_dec   <= w_want_dec & ~w_want_inc;
`ifdef AUTO_CONTRAST_HOLDOFF_EN
              r_hold_cnt <= HOLD_LOAD;
`endif
            end else begin
              r_state <= ST_ACCUM;
            end
          end
`ifdef AUTO_CONTRAST_HOLDOFF_EN
          ST_PULSE:  r_state <= (r_hold_cnt != '0) ? ST_HOLD : ST_ACCUM;
          ST_HOLD: begin
            if (frame_start) begin
              if (r_hold_cnt > CNT_W'(1)) begin
                r_hold_cnt <= r_hold_cnt - CNT_W'(1);
              end else begin
                r_hold_cnt <= '0;
                r_state    <= ST_ACCUM;
              end
            end
          end
`else
          ST_PULSE:  r_state <= ST_ACCUM;
`endif
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
